// File: rtl/fft_input_loader.sv
// fft_input_loader: streams N samples into the FFT buffer (optionally bit-reversed), then starts the FFT and waits for done_o
module fft_input_loader #(
    parameter int N       = 16,
    parameter int SIZE    = 4,
    parameter int DATA_W  = 29,
    parameter int BIT_REV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              done_o,
    output logic              wr_en,
    output logic [SIZE:0]     wr_ptr,
    output logic [DATA_W-1:0] wr_data,
    output logic              flag_start_FFT,
    output logic              busy,
    output logic              overrun,
    output logic [SIZE:0]     load_cnt
);
    typedef enum logic [1:0] {S_LOAD, S_COMMIT, S_WAIT} state_t;
    localparam logic [SIZE:0] LAST = (SIZE+1)'(N-1);
    state_t            r_state;
    logic              r_in_ready, r_wr_en, r_flag, r_busy, r_overrun;
    logic [SIZE:0]     r_wr_ptr, r_load_cnt;
    logic [DATA_W-1:0] r_wr_data;
    logic [SIZE-1:0]   w_rev, w_addr;
    for (genvar b = 0; b < SIZE; b++) begin : g_rev
        assign w_rev[b] = r_load_cnt[SIZE-1-b];
    end
    assign w_addr = (BIT_REV != 0) ? w_rev : r_load_cnt[SIZE-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_load_cnt <= '0;
            r_in_ready <= 1'b1;
            r_wr_en    <= 1'b0;
            r_wr_ptr   <= '0;
            r_wr_data  <= '0;
            r_flag     <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_flag  <= 1'b0;
            if (in_valid && !r_in_ready)
                r_overrun <= 1'b1;
            case (r_state)
                S_LOAD: if (in_valid) begin
                    r_wr_en    <= 1'b1;
                    r_wr_data  <= in_data;
                    r_wr_ptr   <= {1'b0, w_addr};
                    r_load_cnt <= r_load_cnt + 1'b1;
                    r_busy     <= 1'b1;
                    if (r_load_cnt == LAST) begin
                        r_state    <= S_COMMIT;
                        r_in_ready <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    r_state <= S_WAIT;
                    r_flag  <= 1'b1;
                end
                default: if (done_o) begin
                    r_state    <= S_LOAD;
                    r_load_cnt <= '0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end
    assign in_ready       = r_in_ready;
    assign wr_en          = r_wr_en;
    assign wr_ptr         = r_wr_ptr;
    assign wr_data        = r_wr_data;
    assign flag_start_FFT = r_flag;
    assign busy           = r_busy;
    assign overrun        = r_overrun;
    assign load_cnt       = r_load_cnt;
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: scoreboard bench for bit-reversed and natural-order loaders
module tb_fft_input_loader;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic v0 = 1'b0, dn0 = 1'b0, v1 = 1'b0, dn1 = 1'b0;
    logic [28:0] d0 = '0, d1 = '0;
    logic rdy0, we0, fl0, bz0, ov0, rdy1, we1, fl1, bz1, ov1;
    logic [4:0] wp0, lc0, wp1, lc1;
    logic [28:0] wd0, wd1;
    logic [33:0] q0[$], q1[$];
    int total = 0, bad = 0;
    int rev[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_input_loader #(.N(16), .SIZE(4), .DATA_W(29), .BIT_REV(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(rdy0), .done_o(dn0),
        .wr_en(we0), .wr_ptr(wp0), .wr_data(wd0), .flag_start_FFT(fl0), .busy(bz0),
        .overrun(ov0), .load_cnt(lc0));
    fft_input_loader #(.N(16), .SIZE(4), .DATA_W(29), .BIT_REV(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(rdy1), .done_o(dn1),
        .wr_en(we1), .wr_ptr(wp1), .wr_data(wd1), .flag_start_FFT(fl1), .busy(bz1),
        .overrun(ov1), .load_cnt(lc1));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon0
        logic [33:0] e;
        if (we0 === 1'b1) begin
            if (q0.size() == 0) chk("u0 unexpected write", 1, 0);
            else begin
                e = q0.pop_front();
                chk("u0 wr_ptr", 64'(wp0), 64'(e[33:29]));
                chk("u0 wr_data", 64'(wd0), 64'(e[28:0]));
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [33:0] e;
        if (we1 === 1'b1) begin
            if (q1.size() == 0) chk("u1 unexpected write", 1, 0);
            else begin
                e = q1.pop_front();
                chk("u1 wr_ptr", 64'(wp1), 64'(e[33:29]));
                chk("u1 wr_data", 64'(wd1), 64'(e[28:0]));
            end
        end
    end

    task automatic chk_reset0(input string nm);
        chk({nm, " in_ready"}, 64'(rdy0), 1);
        chk({nm, " wr_en"}, 64'(we0), 0);
        chk({nm, " wr_ptr"}, 64'(wp0), 0);
        chk({nm, " wr_data"}, 64'(wd0), 0);
        chk({nm, " flag"}, 64'(fl0), 0);
        chk({nm, " busy"}, 64'(bz0), 0);
        chk({nm, " overrun"}, 64'(ov0), 0);
        chk({nm, " load_cnt"}, 64'(lc0), 0);
    endtask

    // Loads one full frame into u0; gap inserts an idle cycle after each sample,
    // done_at pulses done_o while the sample with that index is offered.
    task automatic load0(input int base, input bit gap, input int done_at);
        for (int k = 0; k < 16; k++) begin
            v0 = 1'b1;
            d0 = 29'(base + k);
            dn0 = (k == done_at);
            q0.push_back({5'(rev[k]), 29'(base + k)});
            step();
            chk("u0 wr_en after accept", 64'(we0), 1);
            chk("u0 load_cnt", 64'(lc0), 64'(k + 1));
            dn0 = 1'b0;
            if (gap && k != 15) begin
                v0 = 1'b0;
                step();
                chk("u0 idle wr_en", 64'(we0), 0);
            end
        end
        v0 = 1'b0;
        chk("u0 in_ready commit", 64'(rdy0), 0);
        chk("u0 flag commit", 64'(fl0), 0);
        chk("u0 busy", 64'(bz0), 1);
        step();
        chk("u0 flag pulse", 64'(fl0), 1);
        chk("u0 wr_en wait", 64'(we0), 0);
        step();
        chk("u0 flag cleared", 64'(fl0), 0);
        chk("u0 in_ready wait", 64'(rdy0), 0);
    endtask

    task automatic release0();
        dn0 = 1'b1;
        step();
        dn0 = 1'b0;
        chk("u0 in_ready after done", 64'(rdy0), 1);
        chk("u0 load_cnt after done", 64'(lc0), 0);
        chk("u0 busy after done", 64'(bz0), 0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk_reset0("reset");
        chk("u1 reset in_ready", 64'(rdy1), 1);
        // scenario 1: back-to-back bit-reversed frame
        load0(0, 1'b0, -1);
        release0();
        // scenario 2: in_valid toggling
        load0('h40, 1'b1, -1);
        chk("u0 load_cnt full", 64'(lc0), 16);
        // scenario 3: valid held during WAIT
        v0 = 1'b1;
        d0 = 29'h1abc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("u0 no write in wait", 64'(we0), 0);
        end
        chk("u0 overrun", 64'(ov0), 1);
        v0 = 1'b0;
        release0();
        chk("u0 overrun sticky", 64'(ov0), 1);
        // scenario 5: done_o during LOAD at load_cnt=5 is ignored
        load0('h80, 1'b0, 5);
        release0();
        // scenario 4: reset after 7 accepts
        for (int k = 0; k < 7; k++) begin
            v0 = 1'b1;
            d0 = 29'('h300 + k);
            q0.push_back({5'(rev[k]), 29'('h300 + k)});
            step();
        end
        v0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset0("mid reset");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("u0 no flag after reset", 64'(fl0), 0);
        end
        load0('h500, 1'b0, -1);
        release0();
        // scenario 6: natural order, done_o coincident with flag
        for (int k = 0; k < 16; k++) begin
            v1 = 1'b1;
            d1 = 29'('h100 + k);
            q1.push_back({5'(k), 29'('h100 + k)});
            step();
        end
        v1 = 1'b0;
        chk("u1 in_ready commit", 64'(rdy1), 0);
        step();
        chk("u1 flag pulse", 64'(fl1), 1);
        dn1 = 1'b1;
        step();
        dn1 = 1'b0;
        chk("u1 flag cleared", 64'(fl1), 0);
        chk("u1 in_ready after done", 64'(rdy1), 1);
        chk("u1 load_cnt after done", 64'(lc1), 0);
        chk("u1 busy after done", 64'(bz1), 0);
        chk("u1 overrun", 64'(ov1), 0);
        step();
        chk("u0 queue drained", 64'(q0.size()), 0);
        chk("u1 queue drained", 64'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
